// File: rtl/net_tx_arbiter.sv
// rtl/net_tx_arbiter.sv - round-robin ARP/UDP transmit arbiter with IFG and frame truncation
module net_tx_arbiter #(
  parameter int IFG_CYCLES    = 12,
  parameter int MAX_FRAME_LEN = 1514
) (
  input  logic       logic_clk,
  input  logic       logic_rst,
  input  logic [7:0] arp_tdata_in,
  input  logic       arp_tvalid_in,
  output logic       arp_tready_out,
  input  logic       arp_tlast_in,
  input  logic [7:0] udp_tdata_in,
  input  logic       udp_tvalid_in,
  output logic       udp_tready_out,
  input  logic       udp_tlast_in,
  output logic [7:0] net_tdata_out,
  output logic       net_tvalid_out,
  input  logic       net_tready_in,
  output logic       net_tlast_out,
  output logic [1:0] net_ttype_out,
  output logic       tx_trunc_err_out,
  output logic       tx_busy_out
);

  typedef enum logic [2:0] {S_IDLE, S_ARP, S_UDP, S_DRAIN, S_GAP} state_t;

  localparam logic [15:0] MAX_LEN  = 16'(MAX_FRAME_LEN);
  localparam logic [15:0] GAP_LAST = 16'(IFG_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic        r_src_udp, w_src_udp_nxt;
  logic        r_rr_udp_last;
  logic [15:0] r_byte_cnt, r_gap_cnt;
  logic [7:0]  r_tdata;
  logic        r_tvalid, r_tlast, r_trunc;
  logic [1:0]  r_ttype;

  logic        w_out_free, w_fwd, w_arp_tready, w_udp_tready;
  logic [7:0]  w_sel_tdata;
  logic        w_sel_tlast, w_xfer, w_load, w_trunc, w_end;
  logic [15:0] w_cnt_inc;

  assign w_out_free   = !r_tvalid || net_tready_in;
  assign w_fwd        = (r_state == S_ARP) || (r_state == S_UDP);
  // DRAIN swallows the rest of a truncated frame without touching the output register
  assign w_arp_tready = ((r_state == S_ARP) && w_out_free) || ((r_state == S_DRAIN) && !r_src_udp);
  assign w_udp_tready = ((r_state == S_UDP) && w_out_free) || ((r_state == S_DRAIN) && r_src_udp);
  assign w_sel_tdata  = r_src_udp ? udp_tdata_in : arp_tdata_in;
  assign w_sel_tlast  = r_src_udp ? udp_tlast_in : arp_tlast_in;
  assign w_xfer       = r_src_udp ? (udp_tvalid_in && w_udp_tready) : (arp_tvalid_in && w_arp_tready);
  assign w_load       = w_xfer && w_fwd;
  assign w_cnt_inc    = r_byte_cnt + 16'd1;
  assign w_trunc      = w_load && !w_sel_tlast && (w_cnt_inc == MAX_LEN);
  assign w_end        = w_xfer && w_sel_tlast;

  always_comb begin
    w_state_nxt   = r_state;
    w_src_udp_nxt = r_src_udp;
    case (r_state)
      S_IDLE: begin
        if (arp_tvalid_in && udp_tvalid_in) begin
          w_src_udp_nxt = !r_rr_udp_last;
          w_state_nxt   = r_rr_udp_last ? S_ARP : S_UDP;
        end else if (arp_tvalid_in) begin
          w_src_udp_nxt = 1'b0;
          w_state_nxt   = S_ARP;
        end else if (udp_tvalid_in) begin
          w_src_udp_nxt = 1'b1;
          w_state_nxt   = S_UDP;
        end
      end
      S_ARP, S_UDP: begin
        if (w_end)        w_state_nxt = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
        else if (w_trunc) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_end) w_state_nxt = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge logic_clk or negedge logic_rst) begin
    if (!logic_rst) begin
      r_state       <= S_IDLE;
      r_src_udp     <= 1'b0;
      r_rr_udp_last <= 1'b1;
      r_byte_cnt    <= 16'd0;
      r_gap_cnt     <= 16'd0;
      r_tdata       <= 8'd0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_ttype       <= 2'b00;
      r_trunc       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_src_udp <= w_src_udp_nxt;
      if (w_end) r_rr_udp_last <= r_src_udp;
      if ((r_state == S_IDLE) || w_end) r_byte_cnt <= 16'd0;
      else if (w_load)                  r_byte_cnt <= w_cnt_inc;
      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 16'd1;
      else                  r_gap_cnt <= 16'd0;
      r_trunc <= w_trunc;
      if (w_load) begin
        r_tdata  <= w_sel_tdata;
        r_tvalid <= 1'b1;
        r_tlast  <= w_sel_tlast || w_trunc;
        r_ttype  <= r_src_udp ? 2'b10 : 2'b01;
      end else if (net_tready_in) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
        r_ttype  <= 2'b00;
      end
    end
  end

  assign arp_tready_out   = w_arp_tready;
  assign udp_tready_out   = w_udp_tready;
  assign net_tdata_out    = r_tdata;
  assign net_tvalid_out   = r_tvalid;
  assign net_tlast_out    = r_tlast;
  assign net_ttype_out    = r_ttype;
  assign tx_trunc_err_out = r_trunc;
  assign tx_busy_out      = (r_state != S_IDLE);

endmodule
